// File: rtl/ikaopll_lfo.sv
// ikaopll_lfo - low-frequency oscillator shared by all OPLL slots.
//
// Produces the tremolo (AM) level and the vibrato (PM) phase. State advances
// once per sample tick, which is qualified from the timing generator's phi1
// negative-edge enable and its cycle-21 strobe.
//
// Ports:
//   i_EMUCLK       emulator master clock, all state on posedge
//   i_IC_n         synchronous active-low reset, overrides any tick
//   i_phi1_NCEN_n  phi1 negative-edge clock enable, active-low
//   i_CYCLE_21     cycle-21 strobe, one phi1 cycle per sample
//   i_TEST_LFO     fast-advance test bit (only with IKAOPLL_LFO_TEST_EN)
//   o_AM_LVL       tremolo level 0..13 (registered)
//   o_PM_PHASE     vibrato phase 0..7 (registered)
//
// Optional feature macro: IKAOPLL_LFO_TEST_EN adds i_TEST_LFO, which bypasses
// the AM prescaler and advances the PM phase by one step per tick.

module ikaopll_lfo #(
  parameter int AM_PRESCALE_BITS = 6,
  parameter int PM_CNTR_BITS     = 13
) (
  input  logic       i_EMUCLK,
  input  logic       i_IC_n,
  input  logic       i_phi1_NCEN_n,
  input  logic       i_CYCLE_21,
`ifdef IKAOPLL_LFO_TEST_EN
  input  logic       i_TEST_LFO,
`endif
  output logic [3:0] o_AM_LVL,
  output logic [2:0] o_PM_PHASE
);

  localparam logic [AM_PRESCALE_BITS-1:0] AM_PRE_ONE =
    {{(AM_PRESCALE_BITS-1){1'b0}}, 1'b1};
  localparam logic [PM_CNTR_BITS-1:0] PM_ONE =
    {{(PM_CNTR_BITS-1){1'b0}}, 1'b1};
  // In test mode the counter jumps by one PM phase step per tick.
  localparam logic [PM_CNTR_BITS-1:0] PM_TEST_INC = PM_ONE << (PM_CNTR_BITS - 3);

  localparam logic [6:0] AM_TOP = 7'd104;

  logic [AM_PRESCALE_BITS-1:0] am_pre_q, am_pre_d;
  logic [6:0]                  am_cnt_q, am_cnt_d;
  logic                        am_dir_q, am_dir_d;   // 0 = up, 1 = down
  logic [PM_CNTR_BITS-1:0]     pm_cnt_q, pm_cnt_d;

  logic                        tick_s;
  logic                        test_s;
  logic                        am_step_s;
  logic [PM_CNTR_BITS-1:0]     pm_inc_s;

`ifdef IKAOPLL_LFO_TEST_EN
  assign test_s = i_TEST_LFO;
`else
  assign test_s = 1'b0;
`endif

  assign tick_s    = ~i_phi1_NCEN_n & i_CYCLE_21;
  // The prescaler keeps counting in test mode; only its step output is bypassed.
  assign am_step_s = tick_s & (test_s | (&am_pre_q));
  assign pm_inc_s  = test_s ? PM_TEST_INC : PM_ONE;

  // Next-state logic for prescaler, AM triangle and PM counter.
  always_comb begin
    am_pre_d = am_pre_q;
    am_cnt_d = am_cnt_q;
    am_dir_d = am_dir_q;
    pm_cnt_d = pm_cnt_q;

    if (tick_s) begin
      am_pre_d = am_pre_q + AM_PRE_ONE;
      pm_cnt_d = pm_cnt_q + pm_inc_s;
    end else begin
      am_pre_d = am_pre_q;
      pm_cnt_d = pm_cnt_q;
    end

    // Triangle bounces at 104 and 0 without dwelling on either endpoint.
    if (am_step_s) begin
      case (am_dir_q)
        1'b0: begin
          if (am_cnt_q == AM_TOP) begin
            am_cnt_d = AM_TOP - 7'd1;
            am_dir_d = 1'b1;
          end else begin
            am_cnt_d = am_cnt_q + 7'd1;
          end
        end
        1'b1: begin
          if (am_cnt_q == 7'd0) begin
            am_cnt_d = 7'd1;
            am_dir_d = 1'b0;
          end else begin
            am_cnt_d = am_cnt_q - 7'd1;
          end
        end
        default: begin
          am_cnt_d = 7'd0;
          am_dir_d = 1'b0;
        end
      endcase
    end else begin
      am_cnt_d = am_cnt_q;
      am_dir_d = am_dir_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge i_EMUCLK) begin
    if (!i_IC_n) begin
      am_pre_q <= '0;
      am_cnt_q <= 7'd0;
      am_dir_q <= 1'b0;
      pm_cnt_q <= '0;
    end else begin
      am_pre_q <= am_pre_d;
      am_cnt_q <= am_cnt_d;
      am_dir_q <= am_dir_d;
      pm_cnt_q <= pm_cnt_d;
    end
  end

  // Outputs are direct slices of registers, so they are glitch-free.
  assign o_AM_LVL   = am_cnt_q[6:3];
  assign o_PM_PHASE = pm_cnt_q[PM_CNTR_BITS-1 -: 3];

endmodule

// File: tb/tb_ikaopll_lfo.sv
// Self-checking bench for ikaopll_lfo. The reference model tracks ticks since
// reset, the number of AM steps taken and the PM count as plain integers, and
// derives the AM level from a closed-form triangle of the step count.

module tb_ikaopll_lfo;

  logic       clk;
  logic       ic_n;
  logic       ncen_n;
  logic       cyc21;
  logic       test_lfo;
  logic [3:0] am_lvl;
  logic [2:0] pm_phase;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int unsigned m_pre;
  int unsigned m_steps;
  int unsigned m_pm;

  ikaopll_lfo #(
    .AM_PRESCALE_BITS(6),
    .PM_CNTR_BITS    (13)
  ) dut (
    .i_EMUCLK     (clk),
    .i_IC_n       (ic_n),
    .i_phi1_NCEN_n(ncen_n),
    .i_CYCLE_21   (cyc21),
`ifdef IKAOPLL_LFO_TEST_EN
    .i_TEST_LFO   (test_lfo),
`endif
    .o_AM_LVL     (am_lvl),
    .o_PM_PHASE   (pm_phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_am_cnt();
    int unsigned p;
    p = m_steps % 208;
    return (p <= 104) ? int'(p) : int'(208 - p);
  endfunction

  // Apply one clock edge with given inputs, advance the model, check outputs.
  task automatic step(input logic ncen, input logic c21, input logic icn);
    bit tm;
    ncen_n = ncen;
    cyc21  = c21;
    ic_n   = icn;
    @(posedge clk);
`ifdef IKAOPLL_LFO_TEST_EN
    tm = test_lfo;
`else
    tm = 1'b0;
`endif
    if (!icn) begin
      m_pre = 0; m_steps = 0; m_pm = 0;
    end else if (!ncen && c21) begin
      if (tm || m_pre == 63) m_steps++;
      m_pre = (m_pre + 1) % 64;
      m_pm  = (m_pm + (tm ? 1024 : 1)) % 8192;
    end
    #1;
    chk("am_lvl", int'(am_lvl), exp_am_cnt() / 8);
    chk("pm_phase", int'(pm_phase), int'(m_pm / 1024));
    chk("am_range", int'(am_lvl <= 4'd13), 1);
  endtask

  int t;
  logic [3:0] hold_am;
  logic [2:0] hold_pm;

  initial begin
    ic_n = 1'b0; ncen_n = 1'b1; cyc21 = 1'b0; test_lfo = 1'b0;
    m_pre = 0; m_steps = 0; m_pm = 0;
    repeat (3) step(1'b1, 1'b0, 1'b0);
    chk("reset_am", int'(am_lvl), 0);
    chk("reset_pm", int'(pm_phase), 0);

    // Progress then reset on a non-enabled edge discards everything.
    repeat (500) step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    chk("midreset_am", int'(am_lvl), 0);
    chk("midreset_pm", int'(pm_phase), 0);
    // Reset wins over a simultaneous tick.
    repeat (700) step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    chk("rst_vs_tick_am", int'(am_lvl), 0);
    chk("rst_vs_tick_pm", int'(pm_phase), 0);

    // Back-to-back ticks through a full AM period, spot-checking milestones.
    for (t = 1; t <= 13376; t++) begin
      step(1'b0, 1'b1, 1'b1);
      case (t)
        511:   chk("am_t511", int'(am_lvl), 0);
        512:   chk("am_t512", int'(am_lvl), 1);
        1023:  chk("pm_t1023", int'(pm_phase), 0);
        1024:  chk("pm_t1024", int'(pm_phase), 1);
        6656:  chk("am_t6656", int'(am_lvl), 13);
        6720:  chk("am_t6720", int'(am_lvl), 12);
        7168:  chk("pm_t7168", int'(pm_phase), 7);
        8192:  chk("pm_t8192", int'(pm_phase), 0);
        13312: chk("am_t13312", int'(am_lvl), 0);
        13376: chk("am_t13376", int'(am_lvl), 0);
        default: ;
      endcase
    end

    // Strobe held high with the enable inactive produces no tick.
    hold_am = am_lvl;
    hold_pm = pm_phase;
    repeat (100) step(1'b1, 1'b1, 1'b1);
    chk("gate_am", int'(am_lvl), int'(hold_am));
    chk("gate_pm", int'(pm_phase), int'(hold_pm));

`ifdef IKAOPLL_LFO_TEST_EN
    test_lfo = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    repeat (104) step(1'b0, 1'b1, 1'b1);
    chk("test_am104", int'(am_lvl), 13);
    for (t = 1; t <= 8; t++) begin
      step(1'b0, 1'b1, 1'b1);
      chk("test_pm_step", int'(pm_phase), t % 8);
    end
    test_lfo = 1'b0;
    repeat (200) step(1'b0, 1'b1, 1'b1);
`endif

    // Randomized enables, strobes, rare resets and (if present) test toggles.
    for (int i = 0; i < 40000; i++) begin
`ifdef IKAOPLL_LFO_TEST_EN
      if ($urandom_range(0, 499) == 0) test_lfo = ~test_lfo;
`endif
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 19999) == 0) ? 1'b0 : 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ikaopll_lfo.md
# ikaopll_lfo

Low-frequency oscillator for the OPLL core. It produces the tremolo (AM) level and vibrato (PM) phase shared by all slots. It sits directly downstream of the timing generator and consumes its phi1 negative-edge clock enable and its cycle-21 strobe, which marks one tick per output sample. Its outputs feed the envelope generator (AM) and the phase generator (PM).

## Interface
- AM_PRESCALE_BITS, 6: width of the AM prescaler; AM steps once every 2^AM_PRESCALE_BITS sample ticks.
- PM_CNTR_BITS, 13: width of the PM counter; the PM phase is its top 3 bits.
- i_EMUCLK  in  1  emulator master clock; all state updates on posedge.
- i_IC_n  in  1  reset, synchronous, active-low.
- i_phi1_NCEN_n  in  1  phi1 negative-edge clock enable, active-low.
- i_CYCLE_21  in  1  timing-generator strobe for master cycle 21; high for one phi1 cycle per sample.
- i_TEST_LFO  in  1  LFO fast-advance test bit. Present only with IKAOPLL_LFO_TEST_EN.
- o_AM_LVL  out  4  tremolo level, 0..13.
- o_PM_PHASE  out  3  vibrato phase, 0..7.

## Operation
- tick = ~i_phi1_NCEN_n & i_CYCLE_21, sampled at a posedge of i_EMUCLK. With no tick, all state holds.
- Reset:
  - Any i_EMUCLK posedge with i_IC_n=0 applies reset, independent of the clock enable.
  - Reset clears am_pre, am_cnt and pm_cnt, sets am_dir to up (0), and drives o_AM_LVL=0 and o_PM_PHASE=0.
  - Reset wins over a simultaneous tick.
  - Reset in mid-sweep discards all progress.
- AM prescaler am_pre (AM_PRESCALE_BITS wide):
  - Increments on each tick and wraps to 0.
  - am_step is asserted on a tick where am_pre is all-ones.
- AM triangle, am_cnt (7 bits, range 0..104) plus am_dir. On am_step:
  - dir up, am_cnt<104: am_cnt+1.
  - dir up, am_cnt==104: am_cnt=103, dir becomes down.
  - dir down, am_cnt>0: am_cnt-1.
  - dir down, am_cnt==0: am_cnt=1, dir becomes up.
  - The value 105 is never reached. A full period is 208 steps = 13312 ticks at the default prescale.
- o_AM_LVL = am_cnt[6:3], registered (max 13).
- PM counter pm_cnt (PM_CNTR_BITS wide):
  - Increments by 1 on each tick and wraps modulo 2^PM_CNTR_BITS.
  - o_PM_PHASE = pm_cnt[PM_CNTR_BITS-1 -: 3].
  - Period is 8192 ticks at the default width.
- The AM and PM paths advance independently and may step on the same tick.

## Timing
- Latency: state and outputs update on the same posedge that qualifies the tick and are visible immediately after it. There is no extra pipeline stage.
- Outputs are registered, glitch-free, and change only on a tick edge or a reset edge.
- The tick rate is one per sample (18 phi1 cycles). The block does not check strobe spacing; every qualified tick counts.
- Holding i_CYCLE_21 high with the enable inactive produces no tick.
- Back-to-back enabled edges with i_CYCLE_21 high each count as a tick.
- First AM step after reset: on the 64th tick, am_cnt goes 0→1.
- First PM phase change after reset: on the 1024th tick, o_PM_PHASE goes 0→1.

## Configuration
- IKAOPLL_LFO_TEST_EN defined:
  - Port i_TEST_LFO exists.
  - While i_TEST_LFO=1, every tick asserts am_step (prescaler bypassed; am_pre still counts), and pm_cnt advances by 2^(PM_CNTR_BITS-3) per tick, so o_PM_PHASE advances by 1 each tick.
  - While i_TEST_LFO=0, behaviour is normal.
- IKAOPLL_LFO_TEST_EN undefined: the port is absent, and the behaviour equals i_TEST_LFO=0.

## Test plan
- Reset: run 500 ticks, then drive i_IC_n=0 on a non-enabled edge → next posedge gives o_AM_LVL=0 and o_PM_PHASE=0. Release, then 63 ticks → am_cnt=0; 64th tick → am_cnt=1.
- AM ramp: 512 ticks after reset → o_AM_LVL=1. 6656 ticks → am_cnt=104, o_AM_LVL=13. 6720 ticks → am_cnt=103, dir down, o_AM_LVL=12.
- AM wrap: 13312 ticks → am_cnt=0, o_AM_LVL=0. 13376 ticks → am_cnt=1, dir up. Over 10^5 ticks, am_cnt is never >104.
- PM: 1023 ticks → o_PM_PHASE=0; 1024 → 1; 7168 → 7; 8192 → 0 (wrap).
- Enable gating: hold i_CYCLE_21=1 for 100 posedges with i_phi1_NCEN_n=1 → no state change. The same with NCEN active for 3 edges → pm_cnt=3.
- Test mode (macro defined): after reset with i_TEST_LFO=1, 104 ticks → o_AM_LVL=13; 8 ticks → o_PM_PHASE returns to 0. Clear i_TEST_LFO → the prescaler resumes from its current am_pre.
